// File: rtl/led_monitor.sv
// Monitors a 16-lamp thermometer LED bar, tracking the sweep direction.
// It flags peaks, kickbacks and completed sweeps, and counts protocol errors.
module led_monitor #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      LED,
  output logic [4:0]       level,
  output logic [1:0]       dir,
  output logic             peak,
  output logic [4:0]       peak_level,
  output logic             kick,
  output logic             seq_done,
  output logic [CNT_W-1:0] seq_cnt,
  output logic             illegal,
  output logic             step_err,
  output logic [CNT_W-1:0] err_cnt
);

  // state  | meaning
  // S_IDLE | bar at rest at level 0
  // S_UP   | bar rising
  // S_DOWN | bar falling after a peak
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_UP = 2'b01, S_DOWN = 2'b10} dir_t;

  dir_t              r_dir, w_dir_nxt;
  logic [4:0]        r_level, w_level_nxt;
  logic [4:0]        r_peak_level, w_pl_nxt;
  logic [CNT_W-1:0]  r_seq_cnt, r_err_cnt;
  logic              r_peak, r_kick, r_done, r_ill, r_serr;
  logic              w_peak, w_kick, w_done, w_ill, w_serr, w_err_ev;
  logic              w_legal;
  logic [4:0]        w_new;
  logic signed [5:0] w_delta;
  logic              w_up, w_dn, w_big;

  always_comb begin
    w_legal = 1'b0;
    w_new   = 5'd0;
    for (int i = 0; i <= 16; i++) begin
      if ({1'b0, LED} == ((17'd1 << i) - 17'd1)) begin
        w_legal = 1'b1;
        w_new   = 5'(i);
      end
    end
  end

  // r_level doubles as the comparison reference: it only ever moves on legal samples.
  assign w_delta = $signed({1'b0, w_new}) - $signed({1'b0, r_level});
  assign w_up    = (w_delta > 6'sd0);
  assign w_dn    = (w_delta < 6'sd0);
  assign w_big   = (w_delta > 6'sd1) || (w_delta < -6'sd1);

  always_comb begin
    w_dir_nxt   = r_dir;
    w_level_nxt = r_level;
    w_pl_nxt    = r_peak_level;
    w_peak      = 1'b0;
    w_kick      = 1'b0;
    w_done      = 1'b0;
    w_ill       = 1'b0;
    w_serr      = 1'b0;
    w_err_ev    = 1'b0;
    if (!w_legal) begin
      w_ill    = 1'b1;
      w_err_ev = 1'b1;
    end else begin
      w_level_nxt = w_new;
      if (w_big) begin
        w_serr   = 1'b1;
        w_err_ev = 1'b1;
      end
      case (r_dir)
        S_IDLE: if (w_up) w_dir_nxt = S_UP;
        S_UP: begin
          if (w_dn) begin
            w_peak   = 1'b1;
            w_pl_nxt = r_level;
            if (w_new == 5'd0) begin
              w_dir_nxt = S_IDLE;
              w_done    = 1'b1;
            end else begin
              w_dir_nxt = S_DOWN;
            end
          end
        end
        S_DOWN: begin
          if (w_up) begin
            w_dir_nxt = S_UP;
            w_kick    = 1'b1;
          end else if (w_dn && (w_new == 5'd0)) begin
            w_dir_nxt = S_IDLE;
            w_done    = 1'b1;
          end
        end
        default: w_dir_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dir        <= S_IDLE;
      r_level      <= 5'd0;
      r_peak_level <= 5'd0;
      r_seq_cnt    <= '0;
      r_err_cnt    <= '0;
      r_peak       <= 1'b0;
      r_kick       <= 1'b0;
      r_done       <= 1'b0;
      r_ill        <= 1'b0;
      r_serr       <= 1'b0;
    end else begin
      r_dir        <= w_dir_nxt;
      r_level      <= w_level_nxt;
      r_peak_level <= w_pl_nxt;
      r_peak       <= w_peak;
      r_kick       <= w_kick;
      r_done       <= w_done;
      r_ill        <= w_ill;
      r_serr       <= w_serr;
      if (w_done) r_seq_cnt <= r_seq_cnt + CNT_W'(1);
      if (w_err_ev && (r_err_cnt != {CNT_W{1'b1}})) r_err_cnt <= r_err_cnt + CNT_W'(1);
    end
  end

  assign level      = r_level;
  assign dir        = r_dir;
  assign peak       = r_peak;
  assign peak_level = r_peak_level;
  assign kick       = r_kick;
  assign seq_done   = r_done;
  assign seq_cnt    = r_seq_cnt;
  assign illegal    = r_ill;
  assign step_err   = r_serr;
  assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_led_monitor.sv
// Bench for led_monitor: directed vector table, sweep scenarios, and a random
// run checked against a rule-level reference model (default and CNT_W=2 copies).
module tb_led_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] LED;

  logic [4:0] level_a, pl_a, level_b, pl_b;
  logic [1:0] dir_a, dir_b;
  logic       peak_a, kick_a, done_a, ill_a, serr_a;
  logic       peak_b, kick_b, done_b, ill_b, serr_b;
  logic [7:0] seq_a, err_a;
  logic [1:0] seq_b, err_b;

  led_monitor #(.CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .LED(LED), .level(level_a), .dir(dir_a), .peak(peak_a),
    .peak_level(pl_a), .kick(kick_a), .seq_done(done_a), .seq_cnt(seq_a),
    .illegal(ill_a), .step_err(serr_a), .err_cnt(err_a));

  led_monitor #(.CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .LED(LED), .level(level_b), .dir(dir_b), .peak(peak_b),
    .peak_level(pl_b), .kick(kick_b), .seq_done(done_b), .seq_cnt(seq_b),
    .illegal(ill_b), .step_err(serr_b), .err_cnt(err_b));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model: plain integers, direction 0 idle / 1 up / 2 down.
  int m_level, m_dir, m_pl, m_seq, m_err;
  int m_peak, m_kick, m_done, m_ill, m_serr;

  task automatic model_step(input logic [15:0] v, input bit r);
    int n, d;
    m_peak = 0; m_kick = 0; m_done = 0; m_ill = 0; m_serr = 0;
    if (r) begin
      m_level = 0; m_dir = 0; m_pl = 0; m_seq = 0; m_err = 0;
      return;
    end
    n = -1;
    for (int k = 0; k <= 16; k++) if (int'(v) == (1 << k) - 1) n = k;
    if (n < 0) begin
      m_ill = 1; m_err++;
      return;
    end
    d = n - m_level;
    if (d > 1 || d < -1) begin m_serr = 1; m_err++; end
    if (d > 0) begin
      if (m_dir == 2) m_kick = 1;
      m_dir = 1;
    end else if (d < 0) begin
      if (m_dir == 1) begin m_peak = 1; m_pl = m_level; end
      if (n == 0) begin m_done = 1; m_seq++; m_dir = 0; end
      else m_dir = 2;
    end
    m_level = n;
  endtask

  task automatic apply(input logic [15:0] v, input bit r);
    @(negedge clk);
    LED = v; reset = r;
    @(posedge clk);
    model_step(v, r);
    #1;
  endtask

  task automatic check_model(input string tag);
    int se_a, se_b;
    se_a = (m_err > 255) ? 255 : m_err;
    se_b = (m_err > 3) ? 3 : m_err;
    chk({tag, ".level"}, int'(level_a), m_level);
    chk({tag, ".dir"}, int'(dir_a), m_dir);
    chk({tag, ".peak"}, int'(peak_a), m_peak);
    chk({tag, ".peak_level"}, int'(pl_a), m_pl);
    chk({tag, ".kick"}, int'(kick_a), m_kick);
    chk({tag, ".seq_done"}, int'(done_a), m_done);
    chk({tag, ".illegal"}, int'(ill_a), m_ill);
    chk({tag, ".step_err"}, int'(serr_a), m_serr);
    chk({tag, ".seq_cnt"}, int'(seq_a), m_seq % 256);
    chk({tag, ".err_cnt"}, int'(err_a), se_a);
    chk({tag, ".seq_cnt_w2"}, int'(seq_b), m_seq % 4);
    chk({tag, ".err_cnt_w2"}, int'(err_b), se_b);
    chk({tag, ".level_w2"}, int'(level_b), m_level);
  endtask

  typedef struct {
    logic [15:0] led;
    bit          rst;
    int lvl, dir, pk, pl, kick, done, ill, serr, seq, err;
  } vec_t;

  vec_t tbl[15];
  int   c_peak, c_kick, c_done, c_serr;

  initial begin
    LED = 16'h0000; reset = 1'b1;
    //           led      rst lvl dir pk pl kick done ill serr seq err
    tbl[0]  = '{16'hFFFF, 1,  0,  0,  0, 0,  0,   0,  0,  0,  0,  0};
    tbl[1]  = '{16'h0001, 0,  1,  1,  0, 0,  0,   0,  0,  0,  0,  0};
    tbl[2]  = '{16'h0003, 0,  2,  1,  0, 0,  0,   0,  0,  0,  0,  0};
    tbl[3]  = '{16'h0005, 0,  2,  1,  0, 0,  0,   0,  1,  0,  0,  1};
    tbl[4]  = '{16'h0007, 0,  3,  1,  0, 0,  0,   0,  0,  0,  0,  1};
    tbl[5]  = '{16'h003F, 0,  6,  1,  0, 0,  0,   0,  0,  1,  0,  2};
    tbl[6]  = '{16'h001F, 0,  5,  2,  1, 6,  0,   0,  0,  0,  0,  2};
    tbl[7]  = '{16'h00FF, 0,  8,  1,  0, 6,  1,   0,  0,  1,  0,  3};
    tbl[8]  = '{16'h00FF, 0,  8,  1,  0, 6,  0,   0,  0,  0,  0,  3};
    tbl[9]  = '{16'h0000, 0,  0,  0,  1, 8,  0,   1,  0,  1,  1,  4};
    tbl[10] = '{16'h03FF, 0, 10,  1,  0, 8,  0,   0,  0,  1,  1,  5};
    tbl[11] = '{16'h01FF, 0,  9,  2,  1, 10, 0,   0,  0,  0,  1,  5};
    tbl[12] = '{16'h03FF, 1,  0,  0,  0, 0,  0,   0,  0,  0,  0,  0};
    tbl[13] = '{16'h0001, 0,  1,  1,  0, 0,  0,   0,  0,  0,  0,  0};
    tbl[14] = '{16'h0000, 0,  0,  0,  1, 1,  0,   1,  0,  0,  1,  0};

    apply(16'h0000, 1);
    for (int i = 0; i < 15; i++) begin
      apply(tbl[i].led, tbl[i].rst);
      chk($sformatf("vec%0d.level", i), int'(level_a), tbl[i].lvl);
      chk($sformatf("vec%0d.dir", i), int'(dir_a), tbl[i].dir);
      chk($sformatf("vec%0d.peak", i), int'(peak_a), tbl[i].pk);
      chk($sformatf("vec%0d.peak_level", i), int'(pl_a), tbl[i].pl);
      chk($sformatf("vec%0d.kick", i), int'(kick_a), tbl[i].kick);
      chk($sformatf("vec%0d.seq_done", i), int'(done_a), tbl[i].done);
      chk($sformatf("vec%0d.illegal", i), int'(ill_a), tbl[i].ill);
      chk($sformatf("vec%0d.step_err", i), int'(serr_a), tbl[i].serr);
      chk($sformatf("vec%0d.seq_cnt", i), int'(seq_a), tbl[i].seq);
      chk($sformatf("vec%0d.err_cnt", i), int'(err_a), tbl[i].err);
    end

    // Clean full ramp up and down.
    apply(16'h0000, 1);
    c_peak = 0; c_done = 0; c_serr = 0;
    for (int n = 1; n <= 16; n++) begin
      apply(16'((32'h1 << n) - 1), 0);
      check_model("ramp_up");
    end
    for (int n = 15; n >= 0; n--) begin
      apply(16'((32'h1 << n) - 1), 0);
      check_model("ramp_dn");
      c_peak += int'(peak_a); c_done += int'(done_a); c_serr += int'(serr_a);
    end
    chk("ramp.peaks", c_peak, 1);
    chk("ramp.peak_level", int'(pl_a), 16);
    chk("ramp.seq_done", c_done, 1);
    chk("ramp.seq_cnt", int'(seq_a), 1);
    chk("ramp.err_cnt", int'(err_a), 0);
    chk("ramp.dir", int'(dir_a), 0);

    // Kickback: 3F, down to 1F, up to FF, down to 0.
    apply(16'h0000, 1);
    c_peak = 0; c_kick = 0; c_done = 0;
    for (int n = 1; n <= 6; n++) apply(16'((32'h1 << n) - 1), 0);
    apply(16'h001F, 0);
    check_model("kb_turn");
    c_peak += int'(peak_a);
    chk("kb.first_peak_level", int'(pl_a), 6);
    for (int n = 6; n <= 8; n++) begin
      apply(16'((32'h1 << n) - 1), 0);
      check_model("kb_up");
      c_kick += int'(kick_a);
    end
    for (int n = 7; n >= 0; n--) begin
      apply(16'((32'h1 << n) - 1), 0);
      check_model("kb_dn");
      c_peak += int'(peak_a); c_done += int'(done_a);
    end
    chk("kb.peaks", c_peak, 2);
    chk("kb.kicks", c_kick, 1);
    chk("kb.seq_done", c_done, 1);
    chk("kb.peak_level", int'(pl_a), 8);

    // Wrap and saturation.
    apply(16'h0000, 1);
    for (int s = 0; s < 5; s++) begin
      apply(16'h0001, 0);
      apply(16'h0000, 0);
      check_model("wrap");
    end
    chk("wrap.seq_cnt_w2", int'(seq_b), 1);
    chk("wrap.seq_cnt_w8", int'(seq_a), 5);
    for (int s = 0; s < 5; s++) begin
      apply(16'h0005, 0);
      check_model("sat");
    end
    chk("sat.err_cnt_w2", int'(err_b), 3);
    chk("sat.err_cnt_w8", int'(err_a), 5);

    // Randomized run against the reference model.
    apply(16'h0000, 1);
    for (int i = 0; i < 2000; i++) begin
      int r, n;
      logic [15:0] v;
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        apply(16'h0000, 1);
      end else if (r < 10) begin
        v = 16'($urandom);
        apply(v, 0);
      end else begin
        n = m_level + int'($urandom_range(0, 4)) - 2;
        if (r > 90) n = int'($urandom_range(0, 16));
        if (n < 0) n = 0;
        if (n > 16) n = 16;
        apply(16'((32'h1 << n) - 1), 0);
      end
      check_model("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
